// File: rtl/matmul_sequencer.sv
// Single-FSM control for one systolic-array matmul pass: weight load,
// skewed input streaming and skewed output write-back.
module matmul_sequencer #(
  parameter int WIDTH_HEIGHT = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int SYS_LAT      = 17
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               reuse_weights,
  input  logic [ADDR_WIDTH:0]                num_rows,
  input  logic [ADDR_WIDTH-1:0]              w_base_addr,
  input  logic [ADDR_WIDTH-1:0]              in_base_addr,
  input  logic [ADDR_WIDTH-1:0]              out_base_addr,
  output logic                               busy,
  output logic                               done,
  output logic [WIDTH_HEIGHT-1:0]            weightMem_rd_en,
  output logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0] weightMem_rd_addr,
  output logic                               fifo_en,
  output logic                               wwrite,
  output logic                               sys_active,
  output logic [WIDTH_HEIGHT-1:0]            inputMem_rd_en,
  output logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0] inputMem_rd_addr,
  output logic [WIDTH_HEIGHT-1:0]            outputMem_wr_en,
  output logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0] outputMem_wr_addr
);

  localparam int W  = WIDTH_HEIGHT;
  localparam int AW = ADDR_WIDTH;
  localparam int LW = W * AW;
  localparam int CW = $clog2((1 << AW) + 2 * W + SYS_LAT + 1);
  localparam logic [AW:0] NMAX = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {
    IDLE, LOAD_W, LATCH_W, COMPUTE, FINISH
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW:0]     n_q, n_d;
  logic [AW-1:0]   wb_q, wb_d, ib_q, ib_d, ob_q, ob_d;
  logic [CW-1:0]   t_end;

  logic            busy_q, busy_d, done_q, done_d;
  logic            fifo_q, fifo_d, wwr_q, wwr_d, act_q, act_d;
  logic [W-1:0]    wen_q, wen_d, ien_q, ien_d, oen_q, oen_d;
  logic [LW-1:0]   wad_q, wad_d, iad_q, iad_d, oad_q, oad_d;
  logic [CW-1:0]   lo, hi;

  assign t_end = CW'(n_q) + CW'(W + SYS_LAT - 2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    wb_d    = wb_q;
    ib_d    = ib_q;
    ob_d    = ob_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d   = (num_rows > NMAX) ? NMAX : num_rows;
          wb_d  = w_base_addr;
          ib_d  = in_base_addr;
          ob_d  = out_base_addr;
          cnt_d = '0;
          if (!reuse_weights)  state_d = LOAD_W;
          else if (n_d == '0)  state_d = FINISH;
          else                 state_d = COMPUTE;
        end
      end
      LOAD_W: begin
        if (cnt_q == CW'(W)) begin
          state_d = LATCH_W;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LATCH_W: state_d = (n_q == '0) ? FINISH : COMPUTE;
      COMPUTE: begin
        if (cnt_q == t_end) begin
          state_d = FINISH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so the registers line up
  // with the state they describe.
  always_comb begin
    busy_d = (state_d != IDLE);
    done_d = (state_d == FINISH);
    fifo_d = 1'b0;
    wwr_d  = 1'b0;
    act_d  = 1'b0;
    wen_d  = '0;
    ien_d  = '0;
    oen_d  = '0;
    wad_d  = '0;
    iad_d  = '0;
    oad_d  = '0;
    lo     = '0;
    hi     = '0;
    unique case (state_d)
      LOAD_W: begin
        if (cnt_d < CW'(W)) begin
          wen_d = '1;
          for (int i = 0; i < W; i++)
            wad_d[i*AW +: AW] = wb_d + cnt_d[AW-1:0];
        end
        fifo_d = (cnt_d != '0);
      end
      LATCH_W: wwr_d = 1'b1;
      COMPUTE: begin
        act_d = 1'b1;
        for (int i = 0; i < W; i++) begin
          lo = CW'(i);
          hi = lo + CW'(n_d);
          if (cnt_d >= lo && cnt_d < hi) begin
            ien_d[i]          = 1'b1;
            iad_d[i*AW +: AW] = ib_d + cnt_d[AW-1:0] - AW'(i);
          end
          lo = CW'(i + SYS_LAT);
          hi = lo + CW'(n_d);
          if (cnt_d >= lo && cnt_d < hi) begin
            oen_d[i]          = 1'b1;
            oad_d[i*AW +: AW] = ob_d + cnt_d[AW-1:0] - AW'(i + SYS_LAT);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      wb_q    <= '0;
      ib_q    <= '0;
      ob_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fifo_q  <= 1'b0;
      wwr_q   <= 1'b0;
      act_q   <= 1'b0;
      wen_q   <= '0;
      ien_q   <= '0;
      oen_q   <= '0;
      wad_q   <= '0;
      iad_q   <= '0;
      oad_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      wb_q    <= wb_d;
      ib_q    <= ib_d;
      ob_q    <= ob_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fifo_q  <= fifo_d;
      wwr_q   <= wwr_d;
      act_q   <= act_d;
      wen_q   <= wen_d;
      ien_q   <= ien_d;
      oen_q   <= oen_d;
      wad_q   <= wad_d;
      iad_q   <= iad_d;
      oad_q   <= oad_d;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign fifo_en           = fifo_q;
  assign wwrite            = wwr_q;
  assign sys_active        = act_q;
  assign weightMem_rd_en   = wen_q;
  assign weightMem_rd_addr = wad_q;
  assign inputMem_rd_en    = ien_q;
  assign inputMem_rd_addr  = iad_q;
  assign outputMem_wr_en   = oen_q;
  assign outputMem_wr_addr = oad_q;

endmodule
